// File: rtl/bin_decoder_engine.sv
// Bypass / terminate bin decoder engine for an arithmetic-coded bitstream.
// A start pulse loads two bytes into the value register. Each accepted
// request then decodes up to MAX_BINS bypass bins, one per cycle, pulling
// one new byte every eight bins.
// Optional feature: define TERM_BIN_EN to let req_mode=1 run a single
// terminate-bin step. When TERM_BIN_EN is undefined, req_mode is ignored.
module bin_decoder_engine #(
    parameter int MAX_BINS = 8,
    parameter int CNT_W    = $clog2(MAX_BINS + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [CNT_W-1:0]    req_num_bins,
    input  logic                req_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MAX_BINS-1:0] out_bins,
    output logic [CNT_W-1:0]    out_count,
    output logic                busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT0 = 3'd1;
    localparam logic [2:0] ST_INIT1 = 3'd2;
    localparam logic [2:0] ST_READY = 3'd3;
    localparam logic [2:0] ST_DEC   = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    localparam logic signed [3:0] BITS_INIT = 4'sb1000;
    localparam logic signed [3:0] BITS_LAST = 4'sb1111;
    localparam logic [8:0]        RANGE_INIT = 9'd510;

    logic [2:0]          r_state;
    logic [8:0]          r_range;
    logic [31:0]         r_value;
    logic signed [3:0]   r_bits_needed;
    logic [CNT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    r_count;
    logic [MAX_BINS-1:0] r_bins;

    logic [31:0]         w_shift_value;
    logic signed [3:0]   w_shift_bits;
    logic                w_shift_byte;
    logic [31:0]         w_byp_thresh;
    logic                w_byp_bin;
    logic [31:0]         w_byp_value;
    logic [31:0]         w_next_value;
    logic [8:0]          w_next_range;
    logic signed [3:0]   w_next_bits;
    logic                w_bin;
    logic                w_need_byte;
    logic                w_stall;
    logic [CNT_W-1:0]    w_req_bins;
    logic                w_req_term;

`ifdef TERM_BIN_EN
    logic                r_term;
    logic [8:0]          w_term_range;
    logic                w_term_bin;

    assign w_req_term   = req_mode;
    assign w_term_range = r_range - 9'd2;
    assign w_term_bin   = (r_value >= {16'b0, w_term_range, 7'b0});
`else
    logic                w_unused_mode;

    assign w_req_term    = 1'b0;
    assign w_unused_mode = req_mode;
`endif

    // Requests asking for more bins than the engine can hold are clamped
    assign w_req_bins = (req_num_bins > CNT_W'(MAX_BINS)) ? CNT_W'(MAX_BINS) : req_num_bins;

    assign req_ready  = (r_state == ST_READY);
    assign out_valid  = (r_state == ST_RESP);
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_READY);
    assign byte_ready = (r_state == ST_INIT0) || (r_state == ST_INIT1) ||
                        ((r_state == ST_DEC) && w_need_byte);
    assign out_bins   = r_bins;
    assign out_count  = r_count;
    assign w_stall    = w_need_byte && !byte_valid;

    // One-bit renormalising shift of value, merging a fresh byte once eight bits are used up
    always_comb begin
        w_shift_byte = (r_bits_needed == BITS_LAST);
        if (w_shift_byte) begin
            w_shift_value = (r_value << 1) + {24'b0, byte_data};
            w_shift_bits  = BITS_INIT;
        end else begin
            w_shift_value = r_value << 1;
            w_shift_bits  = r_bits_needed + 4'sd1;
        end
        w_byp_thresh = {16'b0, r_range, 7'b0};
        w_byp_bin    = (w_shift_value >= w_byp_thresh);
        w_byp_value  = w_byp_bin ? (w_shift_value - w_byp_thresh) : w_shift_value;
    end

    // Choose the next arithmetic state for the current bin step (bypass unless terminate is active)
    always_comb begin
        w_next_value = w_byp_value;
        w_next_range = r_range;
        w_next_bits  = w_shift_bits;
        w_bin        = w_byp_bin;
        w_need_byte  = w_shift_byte;
`ifdef TERM_BIN_EN
        if (r_term) begin
            w_next_value = r_value;
            w_next_range = w_term_range;
            w_next_bits  = r_bits_needed;
            w_bin        = w_term_bin;
            w_need_byte  = 1'b0;
            if (!w_term_bin && !w_term_range[8]) begin
                w_next_value = w_shift_value;
                w_next_range = {w_term_range[7:0], 1'b0};
                w_next_bits  = w_shift_bits;
                w_need_byte  = w_shift_byte;
            end
        end
`endif
    end

`ifdef TERM_BIN_EN
    // Remember whether the accepted request is a terminate step
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_term <= 1'b0;
        else if ((r_state == ST_READY) && req_valid)
            r_term <= req_mode;
    end
`endif

    // Main controller: initialisation, request acceptance, bin stepping and response hold
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_range       <= 9'd0;
            r_value       <= 32'd0;
            r_bits_needed <= BITS_INIT;
            r_remaining   <= '0;
            r_count       <= '0;
            r_bins        <= '0;
        end else if (start) begin
            r_state <= ST_INIT0;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_IDLE;
                ST_INIT0: begin
                    if (byte_valid) begin
                        r_value       <= {16'b0, byte_data, 8'b0};
                        r_range       <= RANGE_INIT;
                        r_bits_needed <= BITS_INIT;
                        r_state       <= ST_INIT1;
                    end
                end
                ST_INIT1: begin
                    if (byte_valid) begin
                        r_value[7:0]  <= byte_data;
                        r_range       <= RANGE_INIT;
                        r_bits_needed <= BITS_INIT;
                        r_state       <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (req_valid) begin
                        r_bins      <= '0;
                        r_count     <= '0;
                        r_remaining <= w_req_term ? CNT_W'(1) : w_req_bins;
                        r_state     <= (w_req_term || (w_req_bins != '0)) ? ST_DEC : ST_RESP;
                    end
                end
                ST_DEC: begin
                    if (!w_stall) begin
                        r_value       <= w_next_value;
                        r_range       <= w_next_range;
                        r_bits_needed <= w_next_bits;
                        r_bins        <= (r_bins << 1) | MAX_BINS'(w_bin);
                        r_count       <= r_count + CNT_W'(1);
                        r_remaining   <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1))
                            r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (out_ready)
                        r_state <= ST_READY;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_decoder_engine.sv
// Directed testbench for bin_decoder_engine (default MAX_BINS=8).
// Expected values are hand-computed from the decoding arithmetic.
// Some expectations change when the design is built with TERM_BIN_EN.
module tb_bin_decoder_engine;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_num_bins;
    logic       req_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_bins;
    logic [3:0] out_count;
    logic       busy;

    int errors;
    int checks;
    int cyc;

    bin_decoder_engine #(.MAX_BINS(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_num_bins (req_num_bins),
        .req_mode     (req_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bins     (out_bins),
        .out_count    (out_count),
        .busy         (busy)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyInit(input logic [7:0] b0, input logic [7:0] b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("init0_byte_ready", {31'b0, byte_ready}, 32'd1);
        checkOutput("init0_busy", {31'b0, busy}, 32'd1);
        byte_valid = 1'b1;
        byte_data  = b0;
        tick();
        byte_data  = b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic applyRequest(input logic [3:0] num, input logic mode);
        req_valid    = 1'b1;
        req_num_bins = num;
        req_mode     = mode;
        tick();
        req_valid    = 1'b0;
        req_mode     = 1'b0;
    endtask

    task automatic applyRelease();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset_n      = 1'b1;
        start        = 1'b0;
        byte_valid   = 1'b0;
        byte_data    = 8'h00;
        req_valid    = 1'b0;
        req_num_bins = 4'd0;
        req_mode     = 1'b0;
        out_ready    = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out_bins", {24'b0, out_bins}, 32'd0);
        checkOutput("rst_out_count", {28'b0, out_count}, 32'd0);
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_range", {23'b0, dut.r_range}, 32'd0);
        checkOutput("rst_value", dut.r_value, 32'd0);
        checkOutput("rst_bits", {28'b0, dut.r_bits_needed}, 32'h8);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        $display("[TB] request while uninitialised is ignored");
        req_valid    = 1'b1;
        req_num_bins = 4'd1;
        tick();
        tick();
        checkOutput("idle_req_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("idle_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("idle_busy", {31'b0, busy}, 32'd0);
        req_valid = 1'b0;

        $display("[TB] init with 0x8D 0x51");
        applyInit(8'h8D, 8'h51);
        checkOutput("init_value", dut.r_value, 32'h8D51);
        checkOutput("init_range", {23'b0, dut.r_range}, 32'd510);
        checkOutput("init_bits", {28'b0, dut.r_bits_needed}, 32'h8);
        checkOutput("init_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("init_busy", {31'b0, busy}, 32'd0);

        $display("[TB] single bypass bin");
        applyRequest(4'd1, 1'b0);
        checkOutput("b1_not_yet", {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput("b1_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("b1_bins", {24'b0, out_bins}, 32'h01);
        checkOutput("b1_count", {28'b0, out_count}, 32'd1);
        checkOutput("b1_value", dut.r_value, 32'd7074);
        checkOutput("b1_bits", {28'b0, dut.r_bits_needed}, 32'h9);
        tick();
        checkOutput("b1_hold_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("b1_hold_bins", {24'b0, out_bins}, 32'h01);
        applyRelease();
        checkOutput("b1_released", {31'b0, out_valid}, 32'd0);
        checkOutput("b1_ready_again", {31'b0, req_ready}, 32'd1);

        $display("[TB] eight bypass bins with byte stall");
        applyInit(8'h8D, 8'h51);
        applyRequest(4'd8, 1'b0);
        repeat (7) tick();
        checkOutput("b8_byte_ready", {31'b0, byte_ready}, 32'd1);
        checkOutput("b8_count7", {28'b0, out_count}, 32'd7);
        checkOutput("b8_value7", dut.r_value, 32'd61056);
        tick();
        checkOutput("b8_stall_count", {28'b0, out_count}, 32'd7);
        checkOutput("b8_stall_value", dut.r_value, 32'd61056);
        checkOutput("b8_stall_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("b8_stall_byte_ready", {31'b0, byte_ready}, 32'd1);
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        tick();
        byte_valid = 1'b0;
        checkOutput("b8_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("b8_bins", {24'b0, out_bins}, 32'h8D);
        checkOutput("b8_count", {28'b0, out_count}, 32'd8);
        checkOutput("b8_bits", {28'b0, dut.r_bits_needed}, 32'h8);
        checkOutput("b8_value", dut.r_value, 32'd56832);
        applyRelease();

        $display("[TB] mode=1 request");
        applyInit(8'h8D, 8'h51);
        applyRequest(4'd1, 1'b1);
        checkOutput("t_no_byte", {31'b0, byte_ready}, 32'd0);
        tick();
        checkOutput("t_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("t_count", {28'b0, out_count}, 32'd1);
`ifdef TERM_BIN_EN
        checkOutput("t_bins", {24'b0, out_bins}, 32'h00);
        checkOutput("t_range", {23'b0, dut.r_range}, 32'd508);
        checkOutput("t_value", dut.r_value, 32'h8D51);
        checkOutput("t_bits", {28'b0, dut.r_bits_needed}, 32'h8);
`else
        checkOutput("t_bins", {24'b0, out_bins}, 32'h01);
        checkOutput("t_range", {23'b0, dut.r_range}, 32'd510);
        checkOutput("t_value", dut.r_value, 32'd7074);
        checkOutput("t_bits", {28'b0, dut.r_bits_needed}, 32'h9);
`endif
        applyRelease();

        $display("[TB] zero-bin request");
        applyRequest(4'd0, 1'b0);
        checkOutput("z_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("z_count", {28'b0, out_count}, 32'd0);
        checkOutput("z_bins", {24'b0, out_bins}, 32'h00);
        applyRelease();

        // 20 does not fit the 4-bit count field; 15 is the largest over-limit request
        $display("[TB] over-limit request is clamped");
        applyInit(8'h8D, 8'h51);
        byte_valid = 1'b1;
        byte_data  = 8'h00;
        applyRequest(4'd15, 1'b0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        byte_valid = 1'b0;
        checkOutput("clamp_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("clamp_latency", cyc, 32'd8);
        checkOutput("clamp_count", {28'b0, out_count}, 32'd8);
        checkOutput("clamp_bins", {24'b0, out_bins}, 32'h8D);
        applyRelease();

        $display("[TB] three bins from 0xC000");
        applyInit(8'hC0, 8'h00);
        applyRequest(4'd3, 1'b0);
        tick();
        tick();
        checkOutput("c3_not_yet", {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput("c3_valid", {31'b0, out_valid}, 32'd1);
        checkOutput("c3_bins", {24'b0, out_bins}, 32'h06);
        checkOutput("c3_count", {28'b0, out_count}, 32'd3);
        checkOutput("c3_value", dut.r_value, 32'd1536);
        applyRelease();

        $display("[TB] start during a request restarts init");
        applyRequest(4'd6, 1'b0);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("rs_busy", {31'b0, busy}, 32'd1);
        checkOutput("rs_byte_ready", {31'b0, byte_ready}, 32'd1);
        checkOutput("rs_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rs_req_ready", {31'b0, req_ready}, 32'd0);
        byte_valid = 1'b1;
        byte_data  = 8'h8D;
        tick();
        byte_data  = 8'h51;
        tick();
        byte_valid = 1'b0;
        checkOutput("rs_value", dut.r_value, 32'h8D51);
        checkOutput("rs_ready", {31'b0, req_ready}, 32'd1);

        $display("[TB] reset during a request");
        applyRequest(4'd6, 1'b0);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        checkOutput("mr_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mr_out_bins", {24'b0, out_bins}, 32'd0);
        checkOutput("mr_out_count", {28'b0, out_count}, 32'd0);
        checkOutput("mr_req_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("mr_byte_ready", {31'b0, byte_ready}, 32'd0);
        checkOutput("mr_busy", {31'b0, busy}, 32'd0);
        checkOutput("mr_range", {23'b0, dut.r_range}, 32'd0);
        checkOutput("mr_value", dut.r_value, 32'd0);
        checkOutput("mr_bits", {28'b0, dut.r_bits_needed}, 32'h8);
        @(negedge clk);
        reset_n      = 1'b1;
        req_valid    = 1'b1;
        req_num_bins = 4'd6;
        repeat (3) tick();
        checkOutput("mr_idle_req_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("mr_idle_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("mr_idle_busy", {31'b0, busy}, 32'd0);
        req_valid = 1'b0;
        applyInit(8'h8D, 8'h51);
        checkOutput("mr_reinit_ready", {31'b0, req_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
